// File: rtl/clock_pkg.sv
// Shared BCD types, limits and helpers for the wall-clock time keeper.
package clock_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned BCD_W   = 2 * DIGIT_W;

   typedef struct packed {
      logic [DIGIT_W-1:0] tens;
      logic [DIGIT_W-1:0] units;
   } bcd_pair_t;

   localparam bcd_pair_t SEC_MAX        = bcd_pair_t'(8'h59);
   localparam bcd_pair_t MIN_MAX        = bcd_pair_t'(8'h59);
   localparam bcd_pair_t HR24_MAX       = bcd_pair_t'(8'h23);
   localparam bcd_pair_t HR24_MIN       = bcd_pair_t'(8'h00);
   localparam bcd_pair_t HR12_MAX       = bcd_pair_t'(8'h12);
   localparam bcd_pair_t HR12_MIN       = bcd_pair_t'(8'h01);
   localparam bcd_pair_t HR12_PM_TOGGLE = bcd_pair_t'(8'h11);

   // Plain +1 on a BCD pair; callers handle wrap at their own limit.
   function automatic bcd_pair_t bcd_inc(input bcd_pair_t v);
      bcd_pair_t r;
      if (v.units == DIGIT_W'(9)) begin
         r.units = '0;
         r.tens  = v.tens + DIGIT_W'(1);
      end else begin
         r.units = v.units + DIGIT_W'(1);
         r.tens  = v.tens;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping MAX_VAL -> MIN_VAL, with a same-cycle carry out.
module bcd_mod_counter
   import clock_pkg::*;
#(
   parameter logic [7:0] MIN_VAL = 8'h00,
   parameter logic [7:0] MAX_VAL = 8'h59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output logic [7:0] value,
   output logic       carry_out
);

   bcd_pair_t cnt_q;
   bcd_pair_t cnt_d;
   logic      at_max;

   assign at_max = (cnt_q == bcd_pair_t'(MAX_VAL));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = bcd_pair_t'(MIN_VAL);
      end else if (inc) begin
         cnt_d = at_max ? bcd_pair_t'(MIN_VAL) : bcd_inc(cnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= bcd_pair_t'(MIN_VAL);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Combinational so the whole carry chain settles within one cycle.
   assign carry_out = inc && !clr && at_max;
   assign value     = cnt_q;

endmodule

// File: rtl/time_keeper.sv
// Wall-clock time keeper: BCD h/m/s from a 1 Hz tick, 12h/24h, set mode, midnight pulse.
module time_keeper
   import clock_pkg::*;
#(
   parameter bit MODE_24H = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sec_tick,
   input  logic       set_mode,
   input  logic       inc_hr,
   input  logic       inc_min,
   output logic [7:0] hr_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       pm,
   output logic       day_tick
);

   localparam bcd_pair_t HR_RESET = MODE_24H ? HR24_MIN : HR12_MAX;

   logic      set_mode_q;
   logic      set_rise;
   logic      run_tick;
   logic      sec_carry;
   logic      min_inc;
   logic      min_carry;
   logic      hr_inc;

   bcd_pair_t hr_q;
   bcd_pair_t hr_d;
   logic      pm_q;
   logic      pm_d;
   logic      day_tick_q;
   logic      day_tick_d;

   // Set mode freezes counting; a tick coinciding with entry is dropped.
   assign set_rise = set_mode && !set_mode_q;
   assign run_tick = sec_tick && !set_mode;
   assign min_inc  = sec_carry || (set_mode && inc_min);
   assign hr_inc   = set_mode ? inc_hr : min_carry;

   bcd_mod_counter #(
      .MIN_VAL (8'h00),
      .MAX_VAL (SEC_MAX)
   ) u_sec (
      .clk       (clk),
      .rst       (rst),
      .inc       (run_tick),
      .clr       (set_rise),
      .value     (sec_bcd),
      .carry_out (sec_carry)
   );

   bcd_mod_counter #(
      .MIN_VAL (8'h00),
      .MAX_VAL (MIN_MAX)
   ) u_min (
      .clk       (clk),
      .rst       (rst),
      .inc       (min_inc),
      .clr       (1'b0),
      .value     (min_bcd),
      .carry_out (min_carry)
   );

   // Hour advance with 12h wrap (12 -> 01) and PM flip at 11 -> 12.
   always_comb begin
      hr_d       = hr_q;
      pm_d       = pm_q;
      day_tick_d = 1'b0;
      if (hr_inc) begin
         if (MODE_24H) begin
            hr_d       = (hr_q == HR24_MAX) ? HR24_MIN : bcd_inc(hr_q);
            day_tick_d = !set_mode && (hr_q == HR24_MAX);
         end else begin
            hr_d = (hr_q == HR12_MAX) ? HR12_MIN : bcd_inc(hr_q);
            if (hr_q == HR12_PM_TOGGLE) begin
               pm_d       = !pm_q;
               day_tick_d = !set_mode && pm_q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hr_q       <= HR_RESET;
         pm_q       <= 1'b0;
         day_tick_q <= 1'b0;
         set_mode_q <= 1'b0;
      end else begin
         hr_q       <= hr_d;
         pm_q       <= pm_d;
         day_tick_q <= day_tick_d;
         set_mode_q <= set_mode;
      end
   end

   assign hr_bcd   = hr_q;
   assign pm       = pm_q;
   assign day_tick = day_tick_q;

endmodule

// File: doc/time_keeper.md
# time_keeper

Consumes the one-cycle-per-second `sec_tick` pulse from the clock divider and maintains wall-clock time as packed BCD hours, minutes and seconds, ready for the display mux. It supports 24-hour or 12-hour (with PM flag) format, a set mode for adjusting hours and minutes from debounced button pulses, and a one-cycle `day_tick` on midnight rollover.

## Interface
Parameters:
- `MODE_24H`, default 1. 1 = 24-hour format, 00–23. 0 = 12-hour format, 12, 01–11, plus `pm`.

Ports:
- `clk`, input, 1: system clock, 100 MHz.
- `rst`, input, 1: synchronous, active-high reset.
- `sec_tick`, input, 1: one-cycle pulse, once per second.
- `set_mode`, input, 1: level. 1 = time held and adjustable; 0 = run.
- `inc_hr`, input, 1: one-cycle pulse, debounced upstream. Increments hours in set mode.
- `inc_min`, input, 1: one-cycle pulse, debounced upstream. Increments minutes in set mode.
- `hr_bcd`, output, 8: hours, BCD, tens in [7:4], units in [3:0].
- `min_bcd`, output, 8: minutes, BCD, 00–59.
- `sec_bcd`, output, 8: seconds, BCD, 00–59.
- `pm`, output, 1: PM flag. Held at 0 when `MODE_24H`=1.
- `day_tick`, output, 1: one-cycle pulse on rollover to 00:00:00 (24h) or 12:00:00 AM (12h).

## Operation
- Reset (synchronous, all outputs):
  - `sec_bcd`=0x00, `min_bcd`=0x00, `day_tick`=0, `pm`=0.
  - `hr_bcd`=0x00 (24h) or 0x12 (12h).
- Run mode (`set_mode`=0), on `sec_tick`=1:
  - Seconds: increment in BCD. The units digit wraps 9→0 and carries to the tens digit; 59→00 carries to minutes.
  - Minutes: same rule; 59→00 carries to hours.
  - Hours, 24h: 23→00 asserts `day_tick`.
  - Hours, 12h: 12→01, 09→10, 11→12. The 11→12 step toggles `pm`. A toggle from 1→0 (11:59:59 PM→12:00:00 AM) asserts `day_tick`.
  - `inc_hr` and `inc_min` are ignored.
- Set mode (`set_mode`=1):
  - `sec_tick` is ignored and counting is frozen.
  - On the rising edge of `set_mode`, `sec_bcd` is cleared to 0x00.
  - `inc_min`: minutes +1, wrapping 59→00, with no carry into hours.
  - `inc_hr`: hours +1 using the same wrap rules as run mode, including the `pm` toggle in 12h. `day_tick` is never asserted in set mode.
  - `inc_hr` and `inc_min` in the same cycle both apply.
- Exit from set mode: counting resumes on the next `sec_tick`. Seconds restart from 00.
- `sec_tick` held high for N cycles counts N seconds. The upstream divider guarantees single-cycle pulses.
- Invalid BCD states are unreachable and need no recovery logic.

## Timing
- All outputs are registered. Time outputs change on the clock edge that samples `sec_tick`, `inc_hr` or `inc_min` high, and are visible the following cycle.
- `day_tick` is high for exactly the one cycle in which the rolled-over value first appears. It is 0 otherwise.
- `set_mode` takes effect in the cycle it is sampled. A `sec_tick` coinciding with `set_mode` rising is dropped, and seconds clear.
- `rst` has priority over every input, including a coincident `sec_tick`.
- The full carry chain (seconds→minutes→hours) completes in one cycle; there is no ripple latency.

## Structure
- Shared package `clock_pkg` holds:
  - BCD limits: `SEC_MAX`=0x59, `MIN_MAX`=0x59, `HR24_MAX`=0x23, `HR12_MAX`=0x12, `HR12_MIN`=0x01.
  - The 8-bit BCD pair type and width constants.
- Sub-module `bcd_mod_counter`:
  - 2-digit BCD counter with parameterised min/max.
  - Ports: `inc`, `clr`, `carry_out`.
  - Instantiated for seconds and minutes.
- Hours logic stays in `time_keeper` because of the 12h special cases and `pm`.
- Size estimate: `time_keeper` about 180 lines, `bcd_mod_counter` about 60 lines.

## Test plan
- Run carry: reset (24h), then 59 `sec_tick` pulses → 00:00:59. One more → 00:01:00, `day_tick`=0 throughout.
- Midnight (24h):
  - Set 23:59, exit set mode, then 59 ticks → 23:59:59.
  - One more tick → 00:00:00 with `day_tick` high for exactly 1 cycle.
- 12h rollovers:
  - 11:59:59, `pm`=0, + tick → 12:00:00, `pm`=1, no `day_tick`.
  - 12:59:59 + tick → 01:00:00, `pm`=1.
  - 11:59:59, `pm`=1, + tick → 12:00:00, `pm`=0, `day_tick` pulse.
- Set mode:
  - Enter at 10:20:35 → 10:20:00 next cycle. 5 `sec_tick` pulses → no change.
  - Simultaneous `inc_hr`+`inc_min` → 11:21:00.
  - `inc_min` at 59 → 00 with hours unchanged.
- Ignored inputs: `inc_hr`/`inc_min` pulses in run mode → no change. A `sec_tick` coincident with `set_mode` rising is not counted.
- Reset mid-operation: assert `rst` at 23:59:59 in the same cycle as `sec_tick` → 00:00:00 next cycle with `day_tick`=0.
